// File: rtl/alu_rr_arbiter_if.sv
// Bundle of signals between the issue ports, the round-robin ALU arbiter
// and the shared ALU.
//   slave  : arbiter side. Takes requests and the ALU result. Drives grants,
//            ALU operands and responses.
//   master : requester/ALU side, the mirror image of slave.
// Signals:
//   flush               kill in-flight ops, block issue this cycle
//   req_valid/req_ready per-requester handshake (ready is one-hot grant)
//   req_a/req_b/req_sel packed per-requester operands and op select
//   alu_a/alu_b/alu_sel registered operands to the ALU
//   alu_result          registered ALU result
//   rsp_valid           one-hot response strobe
//   rsp_result/rsp_zero/rsp_err  shared response payload
interface alu_rr_arbiter_if #(
  parameter int WIDTH   = 32,
  parameter int NUM_REQ = 2
);
  logic                       flush;
  logic [NUM_REQ-1:0]         req_valid;
  logic [NUM_REQ-1:0]         req_ready;
  logic [NUM_REQ*WIDTH-1:0]   req_a;
  logic [NUM_REQ*WIDTH-1:0]   req_b;
  logic [NUM_REQ*4-1:0]       req_sel;
  logic [WIDTH-1:0]           alu_a;
  logic [WIDTH-1:0]           alu_b;
  logic [3:0]                 alu_sel;
  logic [WIDTH-1:0]           alu_result;
  logic [NUM_REQ-1:0]         rsp_valid;
  logic [WIDTH-1:0]           rsp_result;
  logic                       rsp_zero;
  logic                       rsp_err;

  modport slave (
    input  flush, req_valid, req_a, req_b, req_sel, alu_result,
    output req_ready, alu_a, alu_b, alu_sel,
           rsp_valid, rsp_result, rsp_zero, rsp_err
  );

  modport master (
    output flush, req_valid, req_a, req_b, req_sel, alu_result,
    input  req_ready, alu_a, alu_b, alu_sel,
           rsp_valid, rsp_result, rsp_zero, rsp_err
  );
endinterface

// File: rtl/alu_rr_arbiter.sv
// Round-robin arbiter sharing one registered ALU (1-cycle latency) between
// NUM_REQ requesters. It issues one op per cycle with no bubbles. Each result
// is returned to its issuer two cycles after the handshake, together with a
// zero flag and a divide-by-zero flag.
// Ports:
//   clk  clock, all state updates on posedge
//   rst  synchronous active-high reset
//   bus  alu_rr_arbiter_if.slave. Holds the request handshake, the ALU
//        operands and result, and the responses.
module alu_rr_arbiter #(
  parameter int WIDTH   = 32,
  parameter int NUM_REQ = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  alu_rr_arbiter_if.slave      bus
);
  localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [GW-1:0]      ptr;
  logic [NUM_REQ-1:0] grant;
  logic [GW-1:0]      grant_idx;
  logic               grant_any;

  logic [WIDTH-1:0]   alu_a_q, alu_b_q;
  logic [3:0]         alu_sel_q;

  logic               s1_valid, s1_err;
  logic [GW-1:0]      s1_tag;
  logic               s2_valid, s2_err;
  logic [GW-1:0]      s2_tag;

  logic [WIDTH-1:0]   gnt_a, gnt_b;
  logic [3:0]         gnt_sel;
  logic               gnt_div0;
  logic [NUM_REQ-1:0] rsp_vec;

  // Rotate ptr by k places. The wrap is explicit because NUM_REQ need not be
  // a power of two.
  function automatic logic [GW-1:0] rot(input logic [GW-1:0] p, input int k);
    int s;
    s = int'(p) + k;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return GW'(s);
  endfunction

  // Grant the first valid requester at or above ptr. Ready never waits on
  // anything but valid, so requesters must not gate valid on ready.
  always_comb begin
    logic [GW-1:0] cand;
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    cand      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = rot(ptr, k);
      if (!grant_any && bus.req_valid[cand]) begin
        grant_any       = 1'b1;
        grant[cand]     = 1'b1;
        grant_idx       = cand;
      end
    end
    if (bus.flush || rst) begin
      grant     = '0;
      grant_any = 1'b0;
    end
  end

  always_comb begin
    gnt_a    = bus.req_a[int'(grant_idx)*WIDTH +: WIDTH];
    gnt_b    = bus.req_b[int'(grant_idx)*WIDTH +: WIDTH];
    gnt_sel  = bus.req_sel[int'(grant_idx)*4 +: 4];
    gnt_div0 = ((gnt_sel == 4'h4) || (gnt_sel == 4'h5)) && (gnt_b == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr       <= '0;
      alu_a_q   <= '0;
      alu_b_q   <= '0;
      alu_sel_q <= '0;
      s1_valid  <= 1'b0;
      s1_err    <= 1'b0;
      s1_tag    <= '0;
      s2_valid  <= 1'b0;
      s2_err    <= 1'b0;
      s2_tag    <= '0;
    end else begin
      if (grant_any) begin
        ptr       <= (grant_idx == GW'(NUM_REQ - 1)) ? '0 : grant_idx + GW'(1);
        alu_a_q   <= gnt_a;
        alu_b_q   <= gnt_b;
        alu_sel_q <= gnt_sel;
        s1_tag    <= grant_idx;
        s1_err    <= gnt_div0;
      end
      // Without a handshake the ALU operands hold their values. The result of
      // that idle cycle is not delivered because s1_valid drops.
      s1_valid <= grant_any;
      // The op in s1 is still waiting on the ALU, so flush kills it here. The
      // op already in s2 is delivered this cycle.
      s2_valid <= s1_valid & ~bus.flush;
      s2_tag   <= s1_tag;
      s2_err   <= s1_err;
    end
  end

  always_comb begin
    rsp_vec = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (s2_valid && (s2_tag == GW'(i))) rsp_vec[i] = 1'b1;
    end
  end

  assign bus.req_ready  = grant;
  assign bus.alu_a      = alu_a_q;
  assign bus.alu_b      = alu_b_q;
  assign bus.alu_sel    = alu_sel_q;
  assign bus.rsp_valid  = rsp_vec;
  assign bus.rsp_result = bus.alu_result;
  assign bus.rsp_zero   = (bus.alu_result == '0);
  assign bus.rsp_err    = s2_err & s2_valid;
endmodule

// File: tb/tb_alu_rr_arbiter.sv
module tb_alu_rr_arbiter;
  localparam int W = 32;
  localparam int N = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_rr_arbiter_if #(.WIDTH(W), .NUM_REQ(N)) bus();

  alu_rr_arbiter #(.WIDTH(W), .NUM_REQ(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  function automatic logic [W-1:0] alu_fn(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic [3:0] s);
    case (s)
      4'h0: return a & b;
      4'h1: return a | b;
      4'h2: return a ^ b;
      4'h4, 4'h5: return (b == '0) ? '1 : a / b;
      4'h6: return a + b;
      4'h8: return a - b;
      default: return '0;
    endcase
  endfunction

  // Registered ALU with a 1-cycle latency.
  initial bus.alu_result = '0;
  always @(posedge clk) bus.alu_result <= alu_fn(bus.alu_a, bus.alu_b, bus.alu_sel);

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a queue of pending responses, each with the cycle it
  // is due in.
  typedef struct {
    int          due;
    int          tag;
    logic [W-1:0] res;
    bit          err;
  } rsp_t;
  rsp_t q[$];
  int   cyc  = 0;
  int   mptr = 0;

  always @(negedge clk) begin
    logic [N-1:0] exp_rdy;
    logic [N-1:0] exp_rv;
    int g;
    rsp_t e;
    cyc++;
    exp_rdy = '0;
    g = -1;
    if (!(rst || bus.flush)) begin
      for (int k = 0; k < N; k++) begin
        if (g < 0 && bus.req_valid[(mptr + k) % N]) g = (mptr + k) % N;
      end
      if (g >= 0) exp_rdy[g] = 1'b1;
    end
    chk("model_ready", W'(bus.req_ready), W'(exp_rdy));

    exp_rv = '0;
    if (q.size() > 0 && q[0].due == cyc) begin
      exp_rv[q[0].tag] = 1'b1;
      chk("model_err", W'(bus.rsp_err), W'(q[0].err));
      if (!q[0].err) begin
        chk("model_result", bus.rsp_result, q[0].res);
        chk("model_zero", W'(bus.rsp_zero), W'(q[0].res == '0));
      end
    end
    chk("model_rsp_valid", W'(bus.rsp_valid), W'(exp_rv));

    while (q.size() > 0 && q[0].due <= cyc) void'(q.pop_front());
    if (rst) begin
      q.delete();
      mptr = 0;
    end else if (bus.flush) begin
      q.delete();
    end else if (g >= 0) begin
      e.due = cyc + 2;
      e.tag = g;
      e.res = alu_fn(bus.req_a[g*W +: W], bus.req_b[g*W +: W], bus.req_sel[g*4 +: 4]);
      e.err = (bus.req_sel[g*4 +: 4] inside {4'h4, 4'h5}) && (bus.req_b[g*W +: W] == '0);
      q.push_back(e);
      mptr = (g + 1) % N;
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int r, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [3:0] s);
    bus.req_a[r*W +: W] = a;
    bus.req_b[r*W +: W] = b;
    bus.req_sel[r*4 +: 4] = s;
  endtask

  task automatic idle();
    bus.req_valid = '0;
    bus.flush     = 1'b0;
  endtask

  logic [1:0]   exp_rdy3 [6] = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10};
  logic [W-1:0] exp_res3 [6] = '{32'd1, 32'd18, 32'd3, 32'd20, 32'd5, 32'd22};

  initial begin
    rst           = 1'b1;
    bus.flush     = 1'b0;
    bus.req_valid = 2'b11;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.req_sel   = '0;

    // Reset held two cycles with both requesters valid.
    next_cycle(); #3;
    chk("rst_ready", W'(bus.req_ready), 32'h0);
    chk("rst_rsp", W'(bus.rsp_valid), 32'h0);
    chk("rst_alu_sel", W'(bus.alu_sel), 32'h0);
    next_cycle(); #3;
    chk("rst2_ready", W'(bus.req_ready), 32'h0);
    chk("rst2_rsp", W'(bus.rsp_valid), 32'h0);

    // Release: pointer starts at requester 0.
    next_cycle(); rst = 1'b0;
    set_op(0, 32'd40, 32'd2, 4'h6); set_op(1, 32'd50, 32'd2, 4'h6);
    bus.req_valid = 2'b11; #3;
    chk("rel_ready", W'(bus.req_ready), 32'h1);

    // req1 subtract to zero.
    next_cycle(); bus.req_valid = 2'b10; set_op(1, 32'd7, 32'd7, 4'h8); #3;
    chk("sub_ready", W'(bus.req_ready), 32'h2);
    next_cycle(); idle(); #3;
    chk("rel_rsp", W'(bus.rsp_valid), 32'h1);
    chk("rel_result", bus.rsp_result, 32'd42);
    next_cycle(); #3;
    chk("sub_rsp", W'(bus.rsp_valid), 32'h2);
    chk("sub_result", bus.rsp_result, 32'd0);
    chk("sub_zero", W'(bus.rsp_zero), 32'h1);

    // Both requesters valid for six cycles: alternating grants, no bubbles.
    for (int k = 0; k < 8; k++) begin
      next_cycle();
      if (k < 6) begin
        bus.req_valid = 2'b11;
        set_op(0, W'(k), 32'd1, 4'h6);
        set_op(1, W'(16 + k), 32'd1, 4'h6);
      end else begin
        idle();
      end
      #3;
      if (k < 6) chk("rr_ready", W'(bus.req_ready), W'(exp_rdy3[k]));
      if (k >= 2) begin
        chk("rr_rsp", W'(bus.rsp_valid), W'(exp_rdy3[k-2]));
        chk("rr_result", bus.rsp_result, exp_res3[k-2]);
      end
    end

    // req0 add: 5 + 3.
    next_cycle(); bus.req_valid = 2'b01; set_op(0, 32'd5, 32'd3, 4'h6); #3;
    chk("add_ready", W'(bus.req_ready), 32'h1);
    next_cycle(); idle();
    next_cycle(); #3;
    chk("add_rsp", W'(bus.rsp_valid), 32'h1);
    chk("add_result", bus.rsp_result, 32'd8);
    chk("add_zero", W'(bus.rsp_zero), 32'h0);
    chk("add_err", W'(bus.rsp_err), 32'h0);

    // Divide by zero, then a legal divide.
    next_cycle(); bus.req_valid = 2'b01; set_op(0, 32'd9, 32'd0, 4'h5); #3;
    chk("div0_ready", W'(bus.req_ready), 32'h1);
    next_cycle(); set_op(0, 32'd9, 32'd3, 4'h5); #3;
    chk("div_ready", W'(bus.req_ready), 32'h1);
    next_cycle(); idle(); #3;
    chk("div0_rsp", W'(bus.rsp_valid), 32'h1);
    chk("div0_err", W'(bus.rsp_err), 32'h1);
    next_cycle(); #3;
    chk("div_rsp", W'(bus.rsp_valid), 32'h1);
    chk("div_err", W'(bus.rsp_err), 32'h0);
    chk("div_result", bus.rsp_result, 32'd3);

    // Flush kills the op in flight and blocks issue in the flush cycle.
    next_cycle(); bus.req_valid = 2'b01; set_op(0, 32'd1, 32'd2, 4'h6); #3;
    chk("fl_t_ready", W'(bus.req_ready), 32'h1);
    next_cycle(); set_op(0, 32'd4, 32'd4, 4'h6); bus.flush = 1'b1; #3;
    chk("fl_t1_ready", W'(bus.req_ready), 32'h0);
    next_cycle(); bus.flush = 1'b0; bus.req_valid = 2'b10; set_op(1, 32'd10, 32'd20, 4'h6); #3;
    chk("fl_t2_ready", W'(bus.req_ready), 32'h2);
    chk("fl_t2_rsp", W'(bus.rsp_valid), 32'h0);
    next_cycle(); idle(); #3;
    chk("fl_t3_rsp", W'(bus.rsp_valid), 32'h0);
    next_cycle(); #3;
    chk("fl_t4_rsp", W'(bus.rsp_valid), 32'h2);
    chk("fl_t4_result", bus.rsp_result, 32'd30);

    // Reset in the middle of traffic.
    next_cycle(); bus.req_valid = 2'b11; set_op(0, 32'd2, 32'd2, 4'h6); set_op(1, 32'd3, 32'd3, 4'h6);
    next_cycle();
    next_cycle(); rst = 1'b1; #3;
    chk("mrst_ready", W'(bus.req_ready), 32'h0);
    next_cycle(); rst = 1'b0; bus.req_valid = 2'b00; #3;
    chk("mrst_rsp", W'(bus.rsp_valid), 32'h0);
    next_cycle(); bus.req_valid = 2'b11; #3;
    chk("mrst_ptr", W'(bus.req_ready), 32'h1);
    next_cycle(); idle();
    repeat (3) next_cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
